// File: rtl/rob_commit.sv
// rob_commit: reorder buffer that retires instructions in program order.
// Rename allocates entries at the tail and execute marks them done. The head
// retires when it is done, and the physical register it replaced is handed
// back so it can be freed.
// Ports:
//   clk, reset (sync, active-low)
//   alloc_valid/alloc_ready, alloc_with_write, alloc_arch_rd, alloc_new_phy,
//   alloc_old_phy, alloc_rob_id : allocation handshake and payload
//   complete_valid, complete_rob_id : completion report from execute
//   flush : discard everything in flight
//   commit_valid, commit_with_write, commited_wr_register, commit_arch_rd :
//   retirement of the head entry
//   rob_count : occupied entries, 0..DEPTH

`ifndef ARCH_REG_NUM_WIDTH
`define ARCH_REG_NUM_WIDTH 5
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif

module rob_commit #(
  parameter int unsigned ARCH_REG_NUM_WIDTH     = `ARCH_REG_NUM_WIDTH,
  parameter int unsigned PHYSICAL_REG_NUM_WIDTH = `PHYSICAL_REG_NUM_WIDTH,
  parameter int unsigned ROB_ADDR_WIDTH         = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              alloc_valid,
  output logic                              alloc_ready,
  input  logic                              alloc_with_write,
  input  logic [ARCH_REG_NUM_WIDTH-1:0]     alloc_arch_rd,
  input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] alloc_new_phy,
  input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] alloc_old_phy,
  output logic [ROB_ADDR_WIDTH-1:0]         alloc_rob_id,
  input  logic                              complete_valid,
  input  logic [ROB_ADDR_WIDTH-1:0]         complete_rob_id,
  input  logic                              flush,
  output logic                              commit_valid,
  output logic                              commit_with_write,
  output logic [PHYSICAL_REG_NUM_WIDTH-1:0] commited_wr_register,
  output logic [ARCH_REG_NUM_WIDTH-1:0]     commit_arch_rd,
  output logic [ROB_ADDR_WIDTH:0]           rob_count
);

  localparam int unsigned DEPTH = 1 << ROB_ADDR_WIDTH;
  localparam int unsigned PTR_W = ROB_ADDR_WIDTH + 1;

  typedef struct packed {
    logic                              with_write;
    logic [ARCH_REG_NUM_WIDTH-1:0]     arch_rd;
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] new_phy;
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] old_phy;
  } entry_t;

  entry_t                  payload [DEPTH];
  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;
  logic [DEPTH-1:0]        valid_q;
  logic [DEPTH-1:0]        done_q;
  logic [DEPTH-1:0]        valid_d;
  logic [DEPTH-1:0]        done_d;
  logic [ROB_ADDR_WIDTH-1:0] head_idx;
  logic [ROB_ADDR_WIDTH-1:0] tail_idx;
  logic                    empty;
  logic                    full;
  logic                    alloc_fire;
  logic                    complete_fire;
  entry_t                  head_entry;

  // Pointer-derived status; the MSB of each pointer is the wrap bit.
  assign head_idx   = head[ROB_ADDR_WIDTH-1:0];
  assign tail_idx   = tail[ROB_ADDR_WIDTH-1:0];
  assign empty      = (head == tail);
  assign full       = (head_idx == tail_idx) && (head[ROB_ADDR_WIDTH] != tail[ROB_ADDR_WIDTH]);
  assign rob_count  = tail - head;

  assign alloc_ready  = !full && !flush;
  assign alloc_rob_id = tail_idx;
  assign alloc_fire   = alloc_valid && alloc_ready;

  // A completion aimed at the slot being filled this cycle refers to a stale
  // instruction and must not mark the new one done.
  assign complete_fire = complete_valid && valid_q[complete_rob_id]
                         && !(alloc_fire && (complete_rob_id == tail_idx));

  // Reset also suppresses retirement so nothing is freed while discarding.
  assign head_entry   = payload[head_idx];
  assign commit_valid = reset && !flush && !empty && valid_q[head_idx] && done_q[head_idx];

  // Retirement payload is zero when idle; only a writing instruction frees a register.
  always_comb begin
    commit_with_write    = 1'b0;
    commited_wr_register = '0;
    commit_arch_rd       = '0;
    if (commit_valid) begin
      commit_with_write = head_entry.with_write;
      commit_arch_rd    = head_entry.arch_rd;
      if (head_entry.with_write) commited_wr_register = head_entry.old_phy;
    end
  end

  // Next valid/done bits from allocation, completion and retirement.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    if (complete_fire) done_d[complete_rob_id] = 1'b1;
    if (alloc_fire) begin
      valid_d[tail_idx] = 1'b1;
      done_d[tail_idx]  = 1'b0;
    end
    if (commit_valid) begin
      valid_d[head_idx] = 1'b0;
      done_d[head_idx]  = 1'b0;
    end
  end

  // Pointer and status register; reset beats flush, flush beats everything else.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      if (alloc_fire)   tail <= tail + PTR_W'(1);
      if (commit_valid) head <= head + PTR_W'(1);
    end
  end

  // Payload storage, written only on an accepted allocation.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      payload[tail_idx] <= '{with_write: alloc_with_write,
                             arch_rd:    alloc_arch_rd,
                             new_phy:    alloc_new_phy,
                             old_phy:    alloc_old_phy};
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed test of rob_commit against a queue-based model of
// program-order retirement, plus hand-computed literal expectations.
module tb_rob_commit;

  localparam int AW    = 5;
  localparam int PW    = 6;
  localparam int RW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          alloc_valid;
  logic          alloc_ready;
  logic          alloc_with_write;
  logic [AW-1:0] alloc_arch_rd;
  logic [PW-1:0] alloc_new_phy;
  logic [PW-1:0] alloc_old_phy;
  logic [RW-1:0] alloc_rob_id;
  logic          complete_valid;
  logic [RW-1:0] complete_rob_id;
  logic          flush;
  logic          commit_valid;
  logic          commit_with_write;
  logic [PW-1:0] commited_wr_register;
  logic [AW-1:0] commit_arch_rd;
  logic [RW:0]   rob_count;

  rob_commit #(
    .ARCH_REG_NUM_WIDTH(AW),
    .PHYSICAL_REG_NUM_WIDTH(PW),
    .ROB_ADDR_WIDTH(RW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .alloc_valid(alloc_valid),
    .alloc_ready(alloc_ready),
    .alloc_with_write(alloc_with_write),
    .alloc_arch_rd(alloc_arch_rd),
    .alloc_new_phy(alloc_new_phy),
    .alloc_old_phy(alloc_old_phy),
    .alloc_rob_id(alloc_rob_id),
    .complete_valid(complete_valid),
    .complete_rob_id(complete_rob_id),
    .flush(flush),
    .commit_valid(commit_valid),
    .commit_with_write(commit_with_write),
    .commited_wr_register(commited_wr_register),
    .commit_arch_rd(commit_arch_rd),
    .rob_count(rob_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: in-flight instructions in program order.
  typedef struct {
    int id;
    bit ww;
    int arch;
    int oldp;
    bit done;
  } ment_t;

  ment_t q[$];
  int    m_tail = 0;

  function automatic bit m_commit();
    return reset && !flush && (q.size() > 0) && q[0].done;
  endfunction

  always @(posedge clk) begin : model_update
    bit    c;
    bit    a;
    ment_t e;
    if (!reset || flush) begin
      q.delete();
      m_tail = 0;
    end else begin
      c = m_commit();
      a = alloc_valid && (q.size() < DEPTH);
      if (complete_valid)
        foreach (q[i]) if (q[i].id == int'(complete_rob_id)) q[i].done = 1'b1;
      if (c) void'(q.pop_front());
      if (a) begin
        e.id   = m_tail % DEPTH;
        e.ww   = alloc_with_write;
        e.arch = int'(alloc_arch_rd);
        e.oldp = int'(alloc_old_phy);
        e.done = 1'b0;
        q.push_back(e);
        m_tail = (m_tail + 1) % (2 * DEPTH);
      end
    end
  end

  always @(negedge clk) begin : compare
    bit c;
    if (cmp_en) begin
      c = m_commit();
      chk("alloc_ready", 32'(alloc_ready), int'((q.size() < DEPTH) && !flush));
      chk("alloc_rob_id", 32'(alloc_rob_id), m_tail % DEPTH);
      chk("rob_count", 32'(rob_count), q.size());
      chk("commit_valid", 32'(commit_valid), int'(c));
      chk("commit_with_write", 32'(commit_with_write), c ? int'(q[0].ww) : 0);
      chk("commited_wr_register", 32'(commited_wr_register), (c && q[0].ww) ? q[0].oldp : 0);
      chk("commit_arch_rd", 32'(commit_arch_rd), c ? q[0].arch : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    alloc_valid    = 1'b0;
    complete_valid = 1'b0;
    flush          = 1'b0;
    #1;
  endtask

  task automatic set_alloc(input bit ww, input int arch, input int oldp);
    alloc_valid      = 1'b1;
    alloc_with_write = ww;
    alloc_arch_rd    = AW'(arch);
    alloc_old_phy    = PW'(oldp);
    alloc_new_phy    = PW'(oldp + 1);
  endtask

  task automatic do_alloc(input bit ww, input int arch, input int oldp);
    set_alloc(ww, arch, oldp);
    tick();
  endtask

  task automatic do_complete(input int id);
    complete_valid  = 1'b1;
    complete_rob_id = RW'(id);
    tick();
  endtask

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b0; alloc_valid = 1'b0; complete_valid = 1'b0; flush = 1'b0;
    alloc_with_write = 1'b0; alloc_arch_rd = '0; alloc_new_phy = '0;
    alloc_old_phy = '0; complete_rob_id = '0;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    chk("rst_rob_count", 32'(rob_count), 0);
    chk("rst_alloc_ready", 32'(alloc_ready), 1);
    chk("rst_alloc_rob_id", 32'(alloc_rob_id), 0);
    chk("rst_commit_valid", 32'(commit_valid), 0);
    chk("rst_commited_wr", 32'(commited_wr_register), 0);
    tick();
    reset = 1'b1;
    tick();

    // Three allocations, complete the head, one-cycle commit latency.
    chk("a0_id", 32'(alloc_rob_id), 0);
    do_alloc(1, 1, 40);
    chk("a1_id", 32'(alloc_rob_id), 1);
    do_alloc(1, 2, 41);
    do_alloc(1, 3, 42);
    chk("cnt3", 32'(rob_count), 3);
    complete_valid = 1'b1; complete_rob_id = 4'd0; #1;
    chk("no_commit_same_cycle", 32'(commit_valid), 0);
    tick();
    chk("commit0_valid", 32'(commit_valid), 1);
    chk("commit0_wr", 32'(commited_wr_register), 40);
    chk("commit0_arch", 32'(commit_arch_rd), 1);
    chk("commit0_cnt", 32'(rob_count), 3);
    tick();
    chk("after_commit0_cnt", 32'(rob_count), 2);
    chk("after_commit0_cv", 32'(commit_valid), 0);

    // Younger entries complete first; head still pending blocks retirement.
    do_alloc(1, 4, 43);
    do_complete(3);
    chk("ooo_wait_a", 32'(commit_valid), 0);
    do_complete(2);
    chk("ooo_wait_b", 32'(commit_valid), 0);
    do_complete(1);
    chk("inorder_1", 32'(commited_wr_register), 41);
    set_alloc(1, 5, 44); #1;
    chk("alloc_during_commit_id", 32'(alloc_rob_id), 4);
    tick();
    chk("alloc_commit_cnt", 32'(rob_count), 3);
    chk("inorder_2", 32'(commited_wr_register), 42);
    complete_valid = 1'b1; complete_rob_id = 4'd4;
    tick();
    chk("inorder_3", 32'(commited_wr_register), 43);
    chk("inorder_3_cnt", 32'(rob_count), 2);
    tick();
    chk("inorder_4", 32'(commited_wr_register), 44);
    chk("inorder_4_arch", 32'(commit_arch_rd), 5);
    tick();
    chk("drained_cnt", 32'(rob_count), 0);
    chk("drained_cv", 32'(commit_valid), 0);

    // Non-writing instruction retires without freeing a register.
    do_alloc(0, 7, 0);
    do_complete(5);
    chk("nowrite_cv", 32'(commit_valid), 1);
    chk("nowrite_ww", 32'(commit_with_write), 0);
    chk("nowrite_wr", 32'(commited_wr_register), 0);
    chk("nowrite_arch", 32'(commit_arch_rd), 7);
    tick();

    // Flush an empty buffer to return pointers to zero.
    flush = 1'b1; #1;
    chk("flush_ready", 32'(alloc_ready), 0);
    tick();
    chk("flush_id", 32'(alloc_rob_id), 0);

    // Fill to capacity; a commit cycle does not open the door the same cycle.
    for (int i = 0; i < DEPTH; i++) do_alloc(1, i, i + 20);
    chk("full_ready", 32'(alloc_ready), 0);
    chk("full_cnt", 32'(rob_count), 16);
    chk("full_id", 32'(alloc_rob_id), 0);
    set_alloc(1, 9, 60);
    complete_valid = 1'b1; complete_rob_id = 4'd0;
    tick();
    set_alloc(1, 9, 60); #1;
    chk("full_commit_cv", 32'(commit_valid), 1);
    chk("full_commit_wr", 32'(commited_wr_register), 20);
    chk("full_commit_ready", 32'(alloc_ready), 0);
    tick();
    chk("after_full_cnt", 32'(rob_count), 15);
    chk("after_full_ready", 32'(alloc_ready), 1);
    chk("wrap_id", 32'(alloc_rob_id), 0);
    do_alloc(1, 9, 60);
    chk("wrap_cnt", 32'(rob_count), 16);
    chk("wrap_next_id", 32'(alloc_rob_id), 1);

    // Flush overrides alloc, completion and commit in its cycle.
    flush = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) do_alloc(1, i + 10, i + 30);
    do_complete(0);
    set_alloc(1, 20, 50);
    complete_valid = 1'b1; complete_rob_id = 4'd1; flush = 1'b1; #1;
    chk("flush_cv", 32'(commit_valid), 0);
    chk("flush_ar", 32'(alloc_ready), 0);
    tick();
    chk("post_flush_cnt", 32'(rob_count), 0);
    chk("post_flush_id", 32'(alloc_rob_id), 0);
    tick();
    chk("post_flush_cv", 32'(commit_valid), 0);

    // Reset mid-operation discards everything; a late completion is ignored.
    for (int i = 0; i < 8; i++) do_alloc(1, i, i + 8);
    do_complete(1);
    chk("pre_reset_cnt", 32'(rob_count), 8);
    reset = 1'b0;
    set_alloc(1, 3, 3);
    complete_valid = 1'b1; complete_rob_id = 4'd0;
    tick();
    reset = 1'b1; #1;
    chk("post_reset_cnt", 32'(rob_count), 0);
    chk("post_reset_cv", 32'(commit_valid), 0);
    chk("post_reset_id", 32'(alloc_rob_id), 0);
    complete_valid = 1'b1; complete_rob_id = 4'd3;
    tick();
    chk("late_complete_cv", 32'(commit_valid), 0);
    chk("late_complete_cnt", 32'(rob_count), 0);
    do_alloc(1, 2, 2);
    chk("restart_cnt", 32'(rob_count), 1);
    chk("restart_id", 32'(alloc_rob_id), 1);
    tick();
    tick();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 SHALL have parameter ARCH_REG_NUM_WIDTH, default `ARCH_REG_NUM_WIDTH, the architectural register index width.
REQ-002 SHALL have parameter PHYSICAL_REG_NUM_WIDTH, default `PHYSICAL_REG_NUM_WIDTH, the physical register index width.
REQ-003 SHALL have parameter ROB_ADDR_WIDTH, default 4, with depth DEPTH = 1<<ROB_ADDR_WIDTH entries.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-low reset: 0 = reset, sampled on posedge clk.
REQ-006 alloc_valid  input  1  rename stage presents a new instruction.
REQ-007 alloc_ready  output  1  entry available; an allocation is accepted when alloc_valid && alloc_ready.
REQ-008 alloc_with_write  input  1  the instruction writes a destination register.
REQ-009 alloc_arch_rd  input  ARCH_REG_NUM_WIDTH  architectural destination.
REQ-010 alloc_new_phy  input  PHYSICAL_REG_NUM_WIDTH  newly mapped physical destination.
REQ-011 alloc_old_phy  input  PHYSICAL_REG_NUM_WIDTH  previous mapping of alloc_arch_rd, to be freed at commit.
REQ-012 alloc_rob_id  output  ROB_ADDR_WIDTH  index of the tail entry that the accepted allocation takes.
REQ-013 complete_valid  input  1  execute stage reports that an instruction has finished.
REQ-014 complete_rob_id  input  ROB_ADDR_WIDTH  entry that finished.
REQ-015 flush  input  1  discard all in-flight entries.
REQ-016 commit_valid  output  1  head entry retires this cycle.
REQ-017 commit_with_write  output  1  retiring entry wrote a register.
REQ-018 commited_wr_register  output  PHYSICAL_REG_NUM_WIDTH  alloc_old_phy of the retiring entry (register to free).
REQ-019 commit_arch_rd  output  ARCH_REG_NUM_WIDTH  alloc_arch_rd of the retiring entry.
REQ-020 rob_count  output  ROB_ADDR_WIDTH+1  number of occupied entries, range 0..DEPTH.

Function
REQ-021 SHALL be a circular buffer with head and tail pointers of ROB_ADDR_WIDTH+1 bits; the extra MSB is a wrap bit, and both pointers increment modulo 2*DEPTH.
REQ-022 SHALL derive status from the pointers: empty when head==tail; full when the index bits are equal and the wrap bits differ; rob_count = tail-head.
REQ-023 SHALL drive alloc_ready = !full && !flush, combinationally; an allocation is never accepted when full, even if a commit occurs in the same cycle.
REQ-024 SHALL drive alloc_rob_id = tail index bits, combinationally.
REQ-025 On an accepted allocation, SHALL write {valid=1, done=0, with_write, arch_rd, new_phy, old_phy} into the tail entry at the next edge and then increment tail.
REQ-026 On complete_valid, SHALL set done=1 at the next edge only if the addressed entry is valid; a completion to an invalid entry, or to an entry being allocated in the same cycle, SHALL be ignored.
REQ-027 SHALL drive commit_valid = head entry valid && done && !flush, combinationally; commit_valid=0 whenever the buffer is empty.
REQ-028 When commit_valid=1, SHALL drive commit_with_write, commited_wr_register and commit_arch_rd from the head entry; when commit_valid=0, SHALL drive all three to 0.
REQ-029 When commit_valid=1, SHALL clear the head entry's valid bit at the next edge and increment head.
REQ-030 SHALL commit in strict program order, at most one entry per cycle; a completed entry behind an incomplete head SHALL wait.
REQ-031 Latency: completion of the head entry in cycle N SHALL give commit_valid=1 in cycle N+1.
REQ-032 Allocation, completion and commit in the same cycle SHALL all take effect; rob_count changes by (+1 alloc) + (-1 commit).
REQ-033 flush SHALL override allocation, completion and commit in its cycle; at the next edge all valid and done bits clear and head = tail = 0.

Reset
REQ-034 On reset=0 at posedge clk, SHALL set head = tail = 0 and clear all valid and done bits; payload fields need no reset.
REQ-035 During and immediately after reset: alloc_ready=1, alloc_rob_id=0, commit_valid=0, commit_with_write=0, commited_wr_register=0, commit_arch_rd=0, rob_count=0.
REQ-036 Reset asserted mid-operation SHALL discard all entries, with priority over flush, allocation, completion and commit.

Verification
REQ-037 Allocate 3 entries (ids 0,1,2, old_phy 40,41,42), then complete id 0 -> next cycle commit_valid=1, commited_wr_register=40, rob_count goes 3->2.
REQ-038 Complete ids 2 then 1 with id 0 still pending -> no commit; then complete id 0 -> commits of 0,1,2 on three consecutive cycles.
REQ-039 Allocate 16 entries -> alloc_ready=0, rob_count=16; a 17th alloc_valid is not accepted, including in a cycle with a commit; after that commit, the next allocation gets alloc_rob_id=0 and the tail wrap bit toggles.
REQ-040 Allocate with alloc_with_write=0 and complete it -> commit_valid=1, commit_with_write=0, commited_wr_register=0.
REQ-041 With 5 entries in flight, assert flush together with alloc_valid and complete_valid -> no commit, no allocation; next cycle rob_count=0 and alloc_rob_id=0.
REQ-042 Assert reset=0 for one cycle with 8 entries in flight -> next cycle rob_count=0 and commit_valid=0; a late complete_rob_id=3 is ignored.
